scan_chain_n: RTL and testbench
===============================

# scan_chain_n

Parametrised multi-chain mux-D scan register: the generalised successor of the fixed 8-stage scan flop chain. It provides CHAINS independent chains of LENGTH stages, each with functional capture, serial shift and a shadow update register. A shift counter flags each completed full-length unload. The block sits between functional logic and the test access controller, and is the standard scan segment for new blocks.

## Interface
- LENGTH, 8, stages per chain; legal range ≥ 2.
- CHAINS, 1, number of parallel chains; legal range ≥ 1.
- CW, $clog2(LENGTH), shift-counter width; derived, not overridable.
- rclk  in  1  clock; all state updates on the rising edge.
- rreset  in  1  reset, asynchronous and active-high; clears all state.
- rSE  in  1  scan enable; 1 = shift, 0 = capture.
- rSD  in  CHAINS  serial scan-in; bit c feeds chain c.
- rD  in  CHAINS*LENGTH  functional data; bits [c*LENGTH+i] feed stage i of chain c.
- rUPD  in  1  update strobe; copies the chains into the shadow register.
- Q  out  CHAINS*LENGTH  chain contents, same packing as rD.
- SO  out  CHAINS  serial-out; bit c is stage LENGTH-1 of chain c.
- QU  out  CHAINS*LENGTH  shadow (update) register.
- done  out  1  one-cycle pulse after LENGTH consecutive shift cycles.

## Operation
- **Reset** (rreset=1, asynchronous): Q=0, QU=0, SO=0, done=0, shift counter=0.
- **Shift** (rSE=1): for every chain c, stage 0 <= rSD[c] and stage i <= stage i-1 for i ≥ 1. rD is ignored.
- **Capture** (rSE=0): every stage <= its rD bit.
- **Update**: rUPD=1 with rSE=0 makes QU <= Q, using pre-edge contents. QU otherwise holds.
- rUPD=1 with rSE=1 is ignored; QU holds.
- **Shift counter**:
  - Increments on every shift cycle.
  - On the shift edge where count == LENGTH-1: counter wraps to 0 and done=1 for exactly the following cycle.
  - Any capture cycle (rSE=0) clears the counter to 0. done is not raised.
- Continuous shifting produces a done pulse every LENGTH cycles. There is no stall; the chain is always active.
- All chains share rSE, rUPD and the counter. Chains never interact.

## Timing
- Capture latency: rD is visible on Q one edge after a capture cycle.
- Shift latency: the rSD bit sampled on edge k appears on SO at edge k+LENGTH-1. It is visible after that edge.
- done is registered. It is high in the cycle after the LENGTH-th consecutive shift edge.
- QU is updated one edge after rUPD is sampled.
- Simultaneous capture and update: QU receives the old Q and Q receives rD on the same edge.
- Reset mid-shift: the counter and all data clear immediately, and a pending done is dropped. The first shift after reset release counts as shift 1.
- An rSE toggle from 1 to 0 on the edge where count == LENGTH-1 means that edge is a capture. The counter clears and there is no done.

## Structure
- Package scan_pkg holds:
  - mode constants SCAN_SHIFT=1'b1 and SCAN_CAPTURE=1'b0;
  - a function giving counter width from LENGTH.
- Sub-module scan_cell: one mux-D flop with async reset (rclk, rreset, rSE, rSD, rD, Q). It is instantiated CHAINS*LENGTH times by generate loops.
- The top level owns the shadow register, the shift counter and the done flop.

## Test plan
All scenarios use LENGTH=8 and CHAINS=2.
1. **Reset**: assert rreset mid-cycle with Q=16'hFFFF -> Q, QU, SO and done are 0 immediately, before the next edge.
2. **Capture**: rSE=0, rD=16'hA55A, 1 edge -> Q=16'hA55A, SO=2'b10, counter=0, done=0.
3. **Shift**: after scenario 2, rSE=1, rSD=2'b01 for 8 edges -> Q=16'h00FF and SO=2'b01. The SO sequence over the 8 edges unloads 16'hA55A MSB-first per chain. done=1 in the cycle after edge 8 only.
4. **Continuous shift** for 24 edges -> exactly 3 done pulses, spaced 8 cycles apart.
5. **Interrupted shift**: rSE=1 for 5 edges, then rSE=0 for 1 edge, then rSE=1 for 8 edges -> no done after the first 5. One done follows the 8th of the later shifts, with the counter restarted from 0.
6. **Update**: rUPD=1 with rSE=0, Q=16'h1234, rD=16'hBEEF -> QU=16'h1234 and Q=16'hBEEF. Then rUPD=1 with rSE=1 -> QU unchanged.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared scan-mode constants and shift-counter width helper
package scan_pkg;
  localparam logic SCAN_SHIFT   = 1'b1;
  localparam logic SCAN_CAPTURE = 1'b0;
  function automatic int scan_cw(input int len);
    return $clog2(len);
  endfunction
endpackage

// File: rtl/scan_cell.sv
// scan_cell: single mux-D scan flop with asynchronous active-high reset
module scan_cell
  import scan_pkg::*;
(
  input  logic rclk,
  input  logic rreset,
  input  logic rSE,
  input  logic rSD,
  input  logic rD,
  output logic Q
);
  // shift takes the serial input, capture takes functional data
  always_ff @(posedge rclk or posedge rreset)
    if (rreset) Q <= 1'b0;
    else Q <= (rSE == SCAN_SHIFT) ? rSD : rD;
endmodule

// File: rtl/scan_chain_n.sv
// scan_chain_n: CHAINS parallel scan chains of LENGTH cells with shadow register and unload counter
module scan_chain_n
  import scan_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int CHAINS = 1
) (
  input  logic                     rclk,
  input  logic                     rreset,
  input  logic                     rSE,
  input  logic [CHAINS-1:0]        rSD,
  input  logic [CHAINS*LENGTH-1:0] rD,
  input  logic                     rUPD,
  output logic [CHAINS*LENGTH-1:0] Q,
  output logic [CHAINS-1:0]        SO,
  output logic [CHAINS*LENGTH-1:0] QU,
  output logic                     done
);
  localparam int CW = scan_cw(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CHAINS*LENGTH-1:0] qu_q, qu_d;
  logic done_q, done_d;
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    for (genvar i = 0; i < LENGTH; i++) begin : g_cell
      logic sd;
      if (i == 0) begin : g_head
        assign sd = rSD[c];
      end else begin : g_body
        assign sd = Q[c*LENGTH+i-1];
      end
      scan_cell u_cell (
        .rclk  (rclk),
        .rreset(rreset),
        .rSE   (rSE),
        .rSD   (sd),
        .rD    (rD[c*LENGTH+i]),
        .Q     (Q[c*LENGTH+i])
      );
    end
    assign SO[c] = Q[c*LENGTH+LENGTH-1];
  end
  // counter wraps on the LENGTH-th consecutive shift; any capture restarts it
  always_comb begin
    done_d = (rSE == SCAN_SHIFT) && (cnt_q == LAST);
    cnt_d  = (rSE == SCAN_CAPTURE || done_d) ? '0 : cnt_q + CW'(1);
    qu_d   = (rUPD && rSE == SCAN_CAPTURE) ? Q : qu_q;
  end
  // shadow register, counter and done pulse state
  always_ff @(posedge rclk or posedge rreset)
    if (rreset) begin
      cnt_q  <= '0;
      qu_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      qu_q   <= qu_d;
      done_q <= done_d;
    end
  assign QU   = qu_q;
  assign done = done_q;
endmodule

// File: tb/tb_scan_chain_n.sv
// tb_scan_chain_n: directed checks of capture, shift, done pulse, update and async reset
module tb_scan_chain_n;
  localparam int L = 8;
  localparam int C = 2;
  logic rclk = 1'b0;
  logic rreset = 1'b1;
  logic rSE = 1'b0;
  logic rUPD = 1'b0;
  logic [C-1:0] rSD = '0;
  logic [C*L-1:0] rD = '0;
  logic [C*L-1:0] Q, QU;
  logic [C-1:0] SO;
  logic done;
  int tests = 0;
  int fails = 0;
  int pulses;
  logic [15:0] ref_v;
  scan_chain_n #(.LENGTH(L), .CHAINS(C)) dut (
    .rclk  (rclk),
    .rreset(rreset),
    .rSE   (rSE),
    .rSD   (rSD),
    .rD    (rD),
    .rUPD  (rUPD),
    .Q     (Q),
    .SO    (SO),
    .QU    (QU),
    .done  (done)
  );
  always #5 rclk = ~rclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic se, input logic upd, input logic [1:0] sd, input logic [15:0] d);
    rSE = se;
    rUPD = upd;
    rSD = sd;
    rD = d;
    @(posedge rclk);
    @(negedge rclk);
  endtask
  initial begin
    #1;
    chk("por_q", Q, 0);
    chk("por_qu", QU, 0);
    chk("por_done", done, 0);
    @(negedge rclk);
    rreset = 1'b0;
    cyc(0, 0, 2'b00, 16'hFFFF);
    cyc(0, 1, 2'b00, 16'hFFFF);
    for (int k = 1; k <= 8; k++) cyc(1, 0, 2'b11, 16'h0000);
    chk("pre_rst_q", Q, 16'hFFFF);
    chk("pre_rst_qu", QU, 16'hFFFF);
    chk("pre_rst_done", done, 1);
    #2 rreset = 1'b1;
    #1;
    chk("rst_q", Q, 0);
    chk("rst_qu", QU, 0);
    chk("rst_so", SO, 0);
    chk("rst_done", done, 0);
    @(negedge rclk);
    rreset = 1'b0;
    cyc(0, 0, 2'b00, 16'hA55A);
    chk("cap_q", Q, 16'hA55A);
    chk("cap_so", SO, 2'b10);
    chk("cap_done", done, 0);
    ref_v = 16'hA55A;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("unload_so_%0d", k), SO, {ref_v[16-k], ref_v[8-k]});
      cyc(1, 0, 2'b01, 16'h0000);
      chk($sformatf("shift_done_%0d", k), done, (k == 8));
    end
    chk("shift_q", Q, 16'h00FF);
    chk("shift_so", SO, 2'b01);
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 0, 2'b01, 16'h0000);
      if (done) pulses++;
      chk($sformatf("cont_done_%0d", k), done, (k % 8 == 0));
    end
    chk("cont_pulses", pulses, 3);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 2'b00, 16'h0000);
      chk($sformatf("intr_a_done_%0d", k), done, 0);
    end
    cyc(0, 0, 2'b00, 16'h0000);
    chk("intr_cap_done", done, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 2'b00, 16'h0000);
      chk($sformatf("intr_b_done_%0d", k), done, (k == 8));
    end
    for (int k = 1; k <= 7; k++) cyc(1, 0, 2'b00, 16'h0000);
    cyc(0, 0, 2'b00, 16'h0000);
    chk("toggle_cap_done", done, 0);
    cyc(1, 0, 2'b00, 16'h0000);
    chk("toggle_next_done", done, 0);
    for (int k = 1; k <= 3; k++) cyc(1, 0, 2'b00, 16'h0000);
    #2 rreset = 1'b1;
    @(negedge rclk);
    rreset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 2'b00, 16'h0000);
      chk($sformatf("post_rst_done_%0d", k), done, (k == 8));
    end
    cyc(0, 0, 2'b00, 16'h1234);
    chk("upd_pre_q", Q, 16'h1234);
    cyc(0, 1, 2'b00, 16'hBEEF);
    chk("upd_qu", QU, 16'h1234);
    chk("upd_q", Q, 16'hBEEF);
    cyc(1, 1, 2'b00, 16'h0000);
    chk("upd_shift_qu", QU, 16'h1234);
    chk("upd_shift_q", Q, 16'h7CDE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
